// File: rtl/aes_key_expander_if.sv
// Bus between a round-key consumer and the AES key-schedule engine.
// Handshake: the master raises start for at least one cycle with key valid.
// The engine accepts start only when it is not already busy (IDLE or DONE).
// busy is high while words are being expanded. ready is high once the full
// schedule for the accepted key is stored. rk_addr may change every cycle and
// rk_data follows one cycle later.
interface aes_key_expander_if #(
  parameter int KEY_BITS = 128
);
  logic                start;
  logic [KEY_BITS-1:0] key;
  logic                busy;
  logic                ready;
  logic [3:0]          rk_addr;
  logic [127:0]        rk_data;

  modport master (
    output start, key, rk_addr,
    input  busy, ready, rk_data
  );

  modport slave (
    input  start, key, rk_addr,
    output busy, ready, rk_data
  );
endinterface

// File: rtl/aes_key_expander.sv
// Iterative AES key schedule for 128/192/256-bit keys.
// One 32-bit word is expanded per cycle into a local word store.
// Round keys are served through a registered read port.
module aes_key_expander #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                reset,
  aes_key_expander_if.slave   bus,
  output logic [1:0]          o_dbg_state
);

  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  localparam logic [5:0] NK_W      = 6'(NK);
  localparam logic [5:0] LAST_I    = 6'(NW - 1);
  localparam logic [3:0] NR_A      = 4'(NR);
  localparam logic [2:0] WRAP_LAST = 3'(NK - 1);

  // FIPS-197 S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  generate
    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
      $error("aes_key_expander: KEY_BITS must be 128, 192 or 256");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXPAND = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // Byte b sits at bit offset 8*(255-b) = {~b, 3'b000}.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  state_t        r_state;
  state_t        w_next_state;
  logic [31:0]   r_w [NW];
  logic [5:0]    r_i;
  logic [2:0]    r_wrap;
  logic [7:0]    r_rcon;
  logic          r_armed;
  logic [127:0]  r_rk_data;

  logic          w_start_ok;
  logic          w_expand;
  logic [5:0]    w_prev_idx;
  logic [5:0]    w_old_idx;
  logic [31:0]   w_prev;
  logic [31:0]   w_old;
  logic [31:0]   w_t;
  logic [31:0]   w_new;
  logic          w_rd_ok;
  logic [5:0]    w_base;

  // r_armed stays low for the first edge after reset release, so a start that
  // coincides with release is not taken.
  assign w_expand   = (r_state == S_EXPAND);
  assign w_start_ok = bus.start && r_armed && !w_expand;

  // Release guard: set on the first clock edge after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_armed <= 1'b0;
    else        r_armed <= 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic: start from IDLE/DONE, finish after the last word.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (w_start_ok) w_next_state = S_EXPAND;
      S_EXPAND:       if (r_i == LAST_I) w_next_state = S_DONE;
      default:        w_next_state = S_IDLE;
    endcase
  end

  // Indices are parked at 0 outside EXPAND so reads never leave the store.
  assign w_prev_idx = w_expand ? (r_i - 6'd1) : 6'd0;
  assign w_old_idx  = w_expand ? (r_i - NK_W) : 6'd0;
  assign w_prev     = r_w[w_prev_idx];
  assign w_old      = r_w[w_old_idx];

  // Word rule: RotWord/SubWord/rcon at the start of each NK group, an extra
  // SubWord mid-group for 256-bit keys, then XOR with the word NK back.
  always_comb begin
    w_t = w_prev;
    if (r_wrap == 3'd0) begin
      w_t = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {r_rcon, 24'h0};
    end else if (NK == 8 && r_wrap == 3'd4) begin
      w_t = sub_word(w_prev);
    end
    w_new = w_old ^ w_t;
  end

  // Word store, word index, wrap counter and rcon.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NW; k++) r_w[k] <= '0;
      r_i    <= '0;
      r_wrap <= '0;
      r_rcon <= '0;
    end else if (w_start_ok) begin
      for (int k = 0; k < NK; k++) r_w[k] <= bus.key[KEY_BITS-1-32*k -: 32];
      r_i    <= NK_W;
      r_wrap <= '0;
      r_rcon <= 8'h01;
    end else if (w_expand) begin
      r_w[r_i] <= w_new;
      r_i      <= r_i + 6'd1;
      r_wrap   <= (r_wrap == WRAP_LAST) ? 3'd0 : r_wrap + 3'd1;
      if (r_wrap == 3'd0) r_rcon <= xtime(r_rcon);
    end
  end

  assign w_rd_ok = (r_state == S_DONE) && (bus.rk_addr <= NR_A);
  assign w_base  = w_rd_ok ? {bus.rk_addr, 2'b00} : 6'd0;

  // Registered read port: four words of the addressed round, else zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rk_data <= '0;
    end else if (w_rd_ok) begin
      r_rk_data <= {r_w[w_base], r_w[w_base + 6'd1], r_w[w_base + 6'd2], r_w[w_base + 6'd3]};
    end else begin
      r_rk_data <= '0;
    end
  end

  assign bus.busy    = w_expand;
  assign bus.ready   = (r_state == S_DONE);
  assign bus.rk_data = r_rk_data;
  assign o_dbg_state = r_state;

endmodule
